// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// over the shared open-drain ps2_clk/ps2_data lines. The host holds the clock
// low (inhibit), asserts the start bit, releases the clock, and then shifts
// data on each device clock falling edge. It finishes by sampling the device
// ACK and waiting for the bus to return to idle.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   tx_valid/tx_ready     byte handshake; tx_ready is high only in IDLE
//   tx_data[7:0]          command byte, latched on accept
//   ps2_clk_in/data_in    raw pad levels (asynchronous)
//   ps2_clk_oe/data_oe    1 = pull the corresponding line low
//   busy                  high in every state except IDLE
//   done/ack_err/timeout_err  mutually exclusive one-cycle status pulses
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    XFER,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [7:0]       shift;
  logic             parity;
  logic [3:0]       bitcnt;
  logic             ack_ok;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;

  // Two-flop synchronisers; clk_s3 holds the previous synced clock level.
  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;
  logic fall;
  logic timed_out;
  logic lines_idle;

  assign fall       = clk_s3 & ~clk_s2;
  assign timed_out  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign lines_idle = clk_s2 & data_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shift       <= '0;
      parity      <= 1'b0;
      bitcnt      <= '0;
      ack_ok      <= 1'b0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_valid) begin
            shift       <= tx_data;
            parity      <= ~^tx_data;
            bitcnt      <= '0;
            inh_cnt     <= '0;
            state       <= INHIBIT;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            // Start bit goes out while the clock is still held low.
            state       <= RTS;
            ps2_data_oe <= 1'b1;
            to_cnt      <= '0;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        default: begin
          // RTS, XFER, ACK, WAIT_IDLE share the fall-to-fall watchdog. A fall
          // or a successful bus-idle completion in the same cycle wins over it.
          if (timed_out && !fall && !(state == WAIT_IDLE && lines_idle)) begin
            state       <= IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout_err <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= fall ? '0 : to_cnt + 1'b1;
            case (state)
              RTS: begin
                state      <= XFER;
                ps2_clk_oe <= 1'b0;
                to_cnt     <= '0;
              end

              XFER: begin
                if (fall) begin
                  // bitcnt holds the number of falls already seen.
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt < 4'd8) begin
                    ps2_data_oe <= ~shift[bitcnt[2:0]];
                  end else if (bitcnt == 4'd8) begin
                    ps2_data_oe <= ~parity;
                  end else begin
                    ps2_data_oe <= 1'b0;
                    state       <= ACK;
                  end
                end
              end

              ACK: begin
                if (fall) begin
                  ack_ok <= ~data_s2;
                  state  <= WAIT_IDLE;
                end
              end

              WAIT_IDLE: begin
                if (lines_idle) begin
                  done     <= ack_ok;
                  ack_err  <= ~ack_ok;
                  state    <= IDLE;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
                  to_cnt   <= '0;
                end
              end

              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned INH = 200;
  localparam int unsigned TMO = 3000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clock = ~clock;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Expected outcome of a transfer: 0 = done, 1 = ack_err, 2 = timeout_err.
  typedef struct {
    int         kind;
    logic [9:0] frame;
    int         nbits;
  } exp_t;
  exp_t q[$];

  // Device modes: 0 = normal ACK, 1 = never ACKs, 2 = stops after 4 clocks.
  int         dev_mode  = 0;
  int         dev_h     = 20;
  int         dev_falls = 0;
  bit         dev_abort = 1'b0;
  logic [9:0] cap_bits  = '0;
  int         cap_n     = 0;

  function automatic exp_t model(input logic [7:0] d, input int mode);
    exp_t e;
    e.kind  = mode;
    // Odd parity: the parity bit makes the total count of ones odd.
    e.frame = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
    e.nbits = (mode == 2) ? 4 : 10;
    return e;
  endfunction

  // Device model: waits for inhibit followed by request-to-send, then clocks
  // the frame, capturing data just before each rising edge.
  initial begin
    forever begin
      do @(negedge clock); while (clk_line);
      do @(negedge clock); while (!(clk_line && !data_line));
      cap_n = 0;
      cap_bits = '0;
      repeat (dev_h) @(negedge clock);
      for (int i = 1; i <= 11; i++) begin
        if (dev_mode == 2 && i == 5) break;
        dev_clk_low = 1'b1;
        dev_falls = i;
        repeat (dev_h) @(negedge clock);
        if (dev_abort) break;
        if (i <= 10) begin
          cap_bits[i-1] = data_line;
          cap_n = i;
        end
        dev_clk_low = 1'b0;
        repeat (dev_h) @(negedge clock);
        if (dev_abort) break;
        if (i == 10 && dev_mode == 0) dev_data_low = 1'b1;
      end
      dev_clk_low = 1'b0;
      repeat (dev_h) @(negedge clock);
      dev_data_low = 1'b0;
      dev_abort = 1'b0;
    end
  end

  // Scoreboard monitor: every status pulse consumes one expectation.
  initial begin
    exp_t       e;
    int         kind;
    logic [9:0] mask;
    forever begin
      @(negedge clock);
      if (!reset && (done || ack_err || timeout_err)) begin
        check("pulse_onehot", 32'($countones({done, ack_err, timeout_err})), 32'd1);
        if (q.size() == 0) begin
          fail_bound("unexpected_pulse");
        end else begin
          e = q.pop_front();
          kind = done ? 0 : (ack_err ? 1 : 2);
          check("status_kind", 32'(kind), 32'(e.kind));
          check("ready_at_pulse", 32'(tx_ready), 32'd1);
          check("oe_at_pulse", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          check("captured_count", 32'(cap_n), 32'(e.nbits));
          mask = 10'((1 << e.nbits) - 1);
          check("captured_bits", 32'(cap_bits & mask), 32'(e.frame & mask));
        end
      end
    end
  end

  // Inhibit/RTS shape: clock alone low for INH cycles, one cycle with both
  // lines pulled, then clock released with data still pulled.
  initial begin
    int cnt;
    forever begin
      do @(negedge clock); while (!ps2_clk_oe);
      cnt = 0;
      while (ps2_clk_oe && !ps2_data_oe && cnt < int'(INH) + 10) begin
        cnt++;
        @(negedge clock);
      end
      if (reset) continue;
      check("inhibit_len", 32'(cnt), INH);
      check("rts_both", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
      @(negedge clock);
      check("xfer_start", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      fail_bound(name);
      q.delete();
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d, input int mode);
    int n = 0;
    while (!tx_ready && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (!tx_ready) fail_bound("ready_wait");
    dev_mode  = mode;
    dev_falls = 0;
    tx_data   = d;
    tx_valid  = 1'b1;
    q.push_back(model(d, mode));
    @(negedge clock);
    tx_valid = 1'b0;
    wait_drain("transfer_end");
  endtask

  initial begin
    logic [7:0] a, b;
    int         n;

    repeat (3) @(negedge clock);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_outputs", 32'({busy, ps2_clk_oe, ps2_data_oe, done, ack_err, timeout_err}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("idle_ready", 32'(tx_ready), 32'd1);

    send(8'hED, 0);
    send(8'hF4, 0);
    send(8'h00, 0);
    send(8'hFF, 0);
    send(8'hA5, 1);
    send(8'h3C, 2);

    for (int i = 0; i < 8; i++) begin
      dev_h = int'($urandom_range(12, 30));
      send(8'($urandom), (i == 5) ? 2 : int'($urandom_range(0, 1)));
    end
    dev_h = 20;

    // Back-to-back with tx_valid held and tx_data changed mid-transfer.
    a = 8'($urandom);
    b = ~a;
    dev_mode  = 0;
    dev_falls = 0;
    tx_data   = a;
    tx_valid  = 1'b1;
    q.push_back(model(a, 0));
    n = 0;
    while (dev_falls < 3 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (dev_falls < 3) fail_bound("b2b_falls");
    tx_data = b;
    q.push_back(model(b, 0));
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (!tx_ready) fail_bound("b2b_ready");
    check("b2b_done_with_ready", 32'(done), 32'd1);
    @(negedge clock);
    check("b2b_reaccept", 32'({tx_ready, busy, ps2_clk_oe}), 32'b011);
    tx_valid = 1'b0;
    wait_drain("b2b_end");

    // Reset in the middle of the data bits.
    dev_falls = 0;
    dev_mode  = 0;
    tx_data   = 8'h5A;
    tx_valid  = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    n = 0;
    while (dev_falls < 5 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (dev_falls < 5) fail_bound("rst_falls");
    repeat (6) @(negedge clock);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    dev_abort = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_mid_ready", 32'({tx_ready, busy}), 32'b10);
    repeat (300) @(negedge clock);

    send(8'hED, 0);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard.
- Complements the existing PS/2 keyboard receiver. Shares the same ps2_clk/ps2_data lines, which are driven open-drain via output-enable signals.
- Instantiated inside chiseltop next to the receiver. The top level converts each *_oe to a pull-low on the pad.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before the request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum cycles between device clock falling edges before the transfer is aborted (20 ms at 50 MHz).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  request to send tx_data; accepted when tx_valid and tx_ready are both high
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw PS/2 clock pad level (asynchronous)
- ps2_data_in  in  1  raw PS/2 data pad level (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: byte sent and device ACK seen
- ack_err  out  1  one-cycle pulse: device did not ACK
- timeout_err  out  1  one-cycle pulse: transfer aborted on timeout

Behaviour:
- Input synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser. A third clock flop supplies the previous value.
- fall = previous synced clock high and current synced clock low.
- Reset state: IDLE. ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_err=0, timeout_err=0. Counters are cleared.
- Reset asserted mid-transfer: both oe signals are 0 on the next cycle and the byte is dropped.
- IDLE:
  - On accept, latch tx_data into shift[7:0].
  - Latch parity = ~^tx_data (odd parity).
  - Clear bitcnt. Go to INHIBIT.
  - tx_valid is ignored while busy; the latched byte is never altered mid-transfer.
- INHIBIT:
  - clk_oe=1, data_oe=0. Count INHIBIT_CYCLES.
  - On terminal count, go to RTS.
- RTS (request-to-send):
  - data_oe=1 (start bit 0), clk_oe=1 for exactly one cycle.
  - Then go to XFER with clk_oe=0.
  - Data is asserted one cycle before clock is released.
- XFER:
  - clk_oe=0. Each fall advances bitcnt and sets data_oe for the next bit.
  - data_oe = NOT bit value, so a 1 releases the line.
  - fall 1..8 drive shift[0]..shift[7], LSB first.
  - fall 9 drives the parity bit.
  - fall 10 drives the stop bit (data_oe=0). Go to ACK.
  - The data change takes effect in the cycle after fall is detected, while the clock is still low.
- ACK:
  - On the next fall (the 11th), sample synced data.
  - 0 means ACK seen; go to WAIT_IDLE with ack_ok=1.
  - 1 means no ACK; go to WAIT_IDLE with ack_ok=0.
- WAIT_IDLE:
  - Wait until synced clock and synced data are both 1.
  - Then pulse done (if ack_ok) or ack_err (if not) for one cycle, and return to IDLE.
  - tx_ready rises in the same cycle as the pulse.
- Timeout:
  - Active in RTS, XFER, ACK and WAIT_IDLE.
  - The counter clears on every fall and on state entry.
  - On reaching TIMEOUT_CYCLES: pulse timeout_err, force both oe to 0, go to IDLE.
  - done and ack_err are not pulsed on a timeout.
- Concurrency: at most one of done, ack_err and timeout_err is high in any cycle.
- Counter widths: $clog2 of the respective parameter, plus 1. bitcnt is 4 bits.

Test Plan:
- Send 0xED:
  - clk_oe high for 5000 cycles, then data_oe=1 with clk_oe=0.
  - The device model clocks the line at ~12 kHz and captures data at each rising edge.
  - Captured bits must be 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - The model ACKs; done pulses once and tx_ready returns to 1.
- Send 0xF4: captured bits 0,0,1,0,1,1,1,1, parity 0. Send 0x00: parity 1. Send 0xFF: parity 1.
- Device model never ACKs (holds data high on the 11th clock): ack_err pulses one cycle, done stays 0, state returns to IDLE.
- Device model stops clocking after 4 bits: after TIMEOUT_CYCLES, timeout_err pulses, both oe are 0, and tx_ready is 1.
- tx_valid held high throughout a transfer with tx_data changed mid-transfer: only the first byte is sent. The second byte is accepted in the cycle tx_ready rises, and its INHIBIT follows immediately.
- Assert reset during XFER at bit 5: next cycle both oe are 0, tx_ready is 1, and no status pulse occurs.
